// File: rtl/ccc_lock_sequencer.sv
// CCC fabric PLL lock supervisor: synchronizes/filters FAB_LOCK and releases per-domain resets in a staggered order.
// Optional lock watchdog and LOCK_TIMEOUT flag are built only when CCC_LOCK_SEQ_WATCHDOG_EN is defined.
module ccc_lock_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int LOCK_FILTER    = 16,
  parameter int STAGGER        = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   FAB_LOCK,
  input  logic                   HOLD,
  input  logic                   CLR_STATUS,
  output logic [NUM_DOMAINS-1:0] RST_N,
  output logic                   READY,
  output logic [7:0]             LOCK_LOSS_CNT,
  output logic                   LOCK_TIMEOUT,
  output logic [1:0]             STATE
);

  // state     | meaning
  // WAIT_LOCK | all domains in reset, waiting for lock_s
  // FILTER    | counting consecutive lock_s samples
  // RELEASE   | releasing domains one per STAGGER cycles
  // RUN       | all domains released
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || LOCK_FILTER < 1 || LOCK_FILTER > 65535 ||
      STAGGER < 1 || STAGGER > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("ccc_lock_sequencer: parameter out of range");
  end

  localparam logic [16:0] FILT_LAST = 17'(LOCK_FILTER);
  localparam logic [8:0]  STAG_LAST = 9'(STAGGER);

  state_t                 state_q, state_d;
  logic                   sync_q, lock_s;
  logic [15:0]            filt_q, filt_d;
  logic [7:0]             stag_q, stag_d;
  logic [NUM_DOMAINS-1:0] rst_d, rst_next;
  logic                   ready_d;
  logic                   in_seq, loss_evt, rel_start;
  logic [16:0]            filt_inc;
  logic [8:0]             stag_inc;

  assign in_seq   = (state_q == RELEASE) || (state_q == RUN);
  assign filt_inc = {1'b0, filt_q} + 17'd1;
  assign stag_inc = {1'b0, stag_q} + 9'd1;
  assign rst_next = NUM_DOMAINS'({RST_N, 1'b1});
  assign STATE    = state_q;

  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    stag_d    = stag_q;
    rst_d     = RST_N;
    ready_d   = READY;
    loss_evt  = 1'b0;
    rel_start = 1'b0;
    if (HOLD || (in_seq && !lock_s)) begin
      loss_evt = in_seq && !lock_s;
      state_d  = WAIT_LOCK;
      filt_d   = '0;
      stag_d   = '0;
      rst_d    = '0;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            filt_d = 16'd1;
            if (FILT_LAST == 17'd1) rel_start = 1'b1;
            else                    state_d   = FILTER;
          end
        end
        FILTER: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            filt_d  = '0;
          end else if (filt_inc >= FILT_LAST) begin
            rel_start = 1'b1;
          end else begin
            filt_d = filt_inc[15:0];
          end
        end
        RELEASE: begin
          if (stag_inc >= STAG_LAST) begin
            stag_d = '0;
            rst_d  = rst_next;
            if (&rst_next) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            stag_d = stag_inc[7:0];
          end
        end
        default: ;
      endcase
    end
    // Bit 0 rises on the edge that leaves the filter; a single domain is already fully released.
    if (rel_start) begin
      stag_d = '0;
      rst_d  = NUM_DOMAINS'(1);
      if (NUM_DOMAINS == 1) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q        <= 1'b0;
      lock_s        <= 1'b0;
      state_q       <= WAIT_LOCK;
      filt_q        <= '0;
      stag_q        <= '0;
      RST_N         <= '0;
      READY         <= 1'b0;
      LOCK_LOSS_CNT <= '0;
    end else begin
      sync_q  <= FAB_LOCK;
      lock_s  <= sync_q;
      state_q <= state_d;
      filt_q  <= filt_d;
      stag_q  <= stag_d;
      RST_N   <= rst_d;
      READY   <= ready_d;
      if (CLR_STATUS)                             LOCK_LOSS_CNT <= '0;
      else if (loss_evt && LOCK_LOSS_CNT != 8'hFF) LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
    end
  end

`ifdef CCC_LOCK_SEQ_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES);
  logic [15:0] wd_q;
  logic        timeout_q;

  // Counter parks at the limit so the flag can be cleared without re-arming until lock progress resets it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (HOLD || rel_start) begin
        wd_q <= '0;
      end else if ((state_q == WAIT_LOCK || state_q == FILTER) && wd_q != WD_LAST) begin
        wd_q <= wd_q + 16'd1;
        if (wd_q + 16'd1 == WD_LAST) timeout_q <= 1'b1;
      end
      if (CLR_STATUS) timeout_q <= 1'b0;
    end
  end

  assign LOCK_TIMEOUT = timeout_q;
`else
  assign LOCK_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// Self-checking bench for ccc_lock_sequencer: directed scenarios plus randomized lock/hold/clear traffic
// compared every cycle against a release-timeline model.
module tb_ccc_lock_sequencer;
  localparam int ND = 3;
  localparam int LF = 16;
  localparam int ST = 4;
  localparam int TO = 100;
`ifdef CCC_LOCK_SEQ_WATCHDOG_EN
  localparam int WD_ON = 1;
`else
  localparam int WD_ON = 0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          FAB_LOCK = 1'b0;
  logic          HOLD = 1'b0;
  logic          CLR_STATUS = 1'b0;
  logic [ND-1:0] RST_N;
  logic          READY;
  logic [7:0]    LOCK_LOSS_CNT;
  logic          LOCK_TIMEOUT;
  logic [1:0]    STATE;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ccc_lock_sequencer #(
    .NUM_DOMAINS(ND), .LOCK_FILTER(LF), .STAGGER(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FAB_LOCK(FAB_LOCK), .HOLD(HOLD), .CLR_STATUS(CLR_STATUS),
    .RST_N(RST_N), .READY(READY), .LOCK_LOSS_CNT(LOCK_LOSS_CNT), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STATE(STATE)
  );

  // Model: m_good = consecutive lock samples seen, m_rel_t = edges since bit 0 was released (-1 = none).
  bit m_s1 = 0, m_ls = 0, m_to = 0;
  int m_good = 0, m_rel_t = -1, m_cnt = 0, m_wd = 0;

  function automatic int m_bits();
    int b;
    if (m_rel_t < 0) return 0;
    b = m_rel_t / ST + 1;
    return (b > ND) ? ND : b;
  endfunction

  function automatic int m_state();
    if (m_rel_t >= 0) return (m_bits() == ND) ? 3 : 2;
    return (m_good > 0) ? 1 : 0;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin : model
    bit active, loss, enter;
    if (!RESET_N) begin
      m_s1 = 0; m_ls = 0; m_to = 0;
      m_good = 0; m_rel_t = -1; m_cnt = 0; m_wd = 0;
    end else begin
      active = (m_rel_t >= 0);
      loss   = active && !m_ls;
      enter  = 0;
      if (HOLD || loss) begin
        if (loss && m_cnt < 255) m_cnt++;
        m_good = 0;
        m_rel_t = -1;
      end else if (active) begin
        if (m_rel_t < (ND - 1) * ST) m_rel_t++;
      end else if (!m_ls) begin
        m_good = 0;
      end else begin
        m_good++;
        if (m_good >= LF) begin
          m_rel_t = 0;
          enter = 1;
        end
      end
      if (WD_ON != 0) begin
        if (HOLD || enter) m_wd = 0;
        else if (!active && m_wd < TO) begin
          m_wd++;
          if (m_wd == TO) m_to = 1;
        end
      end
      if (CLR_STATUS) begin
        m_cnt = 0;
        m_to = 0;
      end
      m_ls = m_s1;
      m_s1 = FAB_LOCK;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("rst_n", RST_N, (1 << m_bits()) - 1);
    check("ready", READY, (m_bits() == ND) ? 1 : 0);
    check("loss_cnt", LOCK_LOSS_CNT, m_cnt);
    check("timeout", LOCK_TIMEOUT, m_to);
    check("state", STATE, m_state());
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      cmp_model();
    end
  endtask

  // Called just after an active edge; resets are checked while RESET_N is still low.
  task automatic async_reset(input string tag);
    RESET_N = 1'b0;
    #2;
    check({tag, "_rst_n"}, RST_N, 0);
    check({tag, "_ready"}, READY, 0);
    check({tag, "_cnt"}, LOCK_LOSS_CNT, 0);
    check({tag, "_to"}, LOCK_TIMEOUT, 0);
    check({tag, "_state"}, STATE, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic wait_rst0(input string tag, output int n);
    n = 0;
    while (RST_N[0] !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check(tag, RST_N[0], 1);
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (READY !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check(tag, READY, 1);
  endtask

  initial begin
    int n;
    #12;
    check("reset_rst_n", RST_N, 0);
    check("reset_state", STATE, 0);
    check("reset_cnt", LOCK_LOSS_CNT, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Watchdog with no lock
    tick(99);
    check("wd_before", LOCK_TIMEOUT, 0);
    tick(1);
    check("wd_at_limit", LOCK_TIMEOUT, WD_ON);

    // Nominal release, edges counted from the first edge after reset release
    @(posedge CLK); #1;
    async_reset("rst1");
    FAB_LOCK = 1'b1;
    tick(17);
    check("nom_e16", RST_N, 3'b000);
    tick(1);
    check("nom_e17", RST_N, 3'b001);
    tick(4);
    check("nom_e21", RST_N, 3'b011);
    tick(4);
    check("nom_e25", RST_N, 3'b111);
    check("nom_ready", READY, 1);
    check("nom_state", STATE, 3);

    // Loss in RUN: drop before edge 40
    tick(14);
    FAB_LOCK = 1'b0;
    tick(2);
    check("run_loss_m1", RST_N, 3'b111);
    tick(1);
    check("run_loss_rst", RST_N, 3'b000);
    check("run_loss_ready", READY, 0);
    check("run_loss_cnt", LOCK_LOSS_CNT, 1);

    // Loss between bit 0 and bit 1
    FAB_LOCK = 1'b1;
    wait_rst0("rel_wait", n);
    FAB_LOCK = 1'b0;
    tick(3);
    check("rel_loss_rst", RST_N, 3'b000);
    check("rel_loss_cnt", LOCK_LOSS_CNT, 2);

    // Filter dropout: 10 high, 3 low, then high; release 18 edges after the final rise
    tick(4);
    FAB_LOCK = 1'b1;
    tick(10);
    FAB_LOCK = 1'b0;
    tick(3);
    FAB_LOCK = 1'b1;
    wait_rst0("drop_wait", n);
    check("drop_latency", n, 18);
    check("drop_cnt", LOCK_LOSS_CNT, 2);

    // HOLD in RUN, then release it with lock_s already high
    wait_ready("hold_wait", n);
    HOLD = 1'b1;
    tick(1);
    check("hold_rst", RST_N, 3'b000);
    check("hold_state", STATE, 0);
    check("hold_cnt", LOCK_LOSS_CNT, 2);
    tick(5);
    HOLD = 1'b0;
    wait_rst0("hold_rel0", n);
    check("hold_rel0_lat", n, 16);
    wait_ready("hold_ready", n);
    check("hold_ready_lat", n, 8);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      FAB_LOCK = 1'b1;
      wait_rst0("sat_wait", n);
      FAB_LOCK = 1'b0;
      tick(3);
    end
    check("sat_cnt", LOCK_LOSS_CNT, 255);

    // Clear coinciding with an increment
    FAB_LOCK = 1'b1;
    wait_rst0("clr_wait", n);
    FAB_LOCK = 1'b0;
    tick(2);
    CLR_STATUS = 1'b1;
    tick(1);
    CLR_STATUS = 1'b0;
    check("clr_cnt", LOCK_LOSS_CNT, 0);
    check("clr_rst", RST_N, 3'b000);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) FAB_LOCK = ~FAB_LOCK;
      if (HOLD) begin
        if ($urandom_range(3) == 0) HOLD = 1'b0;
      end else if ($urandom_range(79) == 0) begin
        HOLD = 1'b1;
      end
      CLR_STATUS = ($urandom_range(99) == 0);
      if ($urandom_range(1499) == 0) begin
        async_reset("rnd_reset");
      end else begin
        tick(1);
      end
    end
    CLR_STATUS = 1'b0;
    HOLD = 1'b0;

    // Async reset mid-release
    FAB_LOCK = 1'b0;
    tick(4);
    FAB_LOCK = 1'b1;
    wait_rst0("mid_wait", n);
    tick(1);
    async_reset("mid_rel");
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ccc_lock_sequencer.md
# ccc_lock_sequencer

Supervises the MSS clock conditioning circuit's fabric PLL lock and sequences the fabric reset release that depends on it. It synchronizes and filters the asynchronous `FAB_LOCK` status, then deasserts per-domain active-low resets in a staggered order. On loss of lock it re-asserts all resets. It runs from a free-running clock that is not derived from the PLL, and it keeps lock-loss and lock-timeout status for the MSS firmware.

## Interface
Parameters:
- `NUM_DOMAINS`, 3: number of sequenced reset outputs, 1..8.
- `LOCK_FILTER`, 16: consecutive synchronized-lock samples required before release, 1..65535.
- `STAGGER`, 4: cycles between successive domain releases, 1..255.
- `TIMEOUT_CYCLES`, 50000: watchdog limit while unlocked, 1..65535.

Ports:
- `CLK`  in  1: free-running clock (RCOSC_CLKOUT), never PLL-derived.
- `RESET_N`  in  1: asynchronous active-low reset. This is the only clock and the only reset of the block.
- `FAB_LOCK`  in  1: CCC fabric lock, asynchronous to `CLK`.
- `HOLD`  in  1: firmware request to hold all domains in reset, synchronous.
- `CLR_STATUS`  in  1: single-cycle pulse that clears `LOCK_LOSS_CNT` and `LOCK_TIMEOUT`.
- `RST_N`  out  NUM_DOMAINS: per-domain active-low resets. Bit 0 is released first.
- `READY`  out  1: all domains released.
- `LOCK_LOSS_CNT`  out  8: saturating count of lock losses after release began.
- `LOCK_TIMEOUT`  out  1: sticky watchdog flag.
- `STATE`  out  2: 0 WAIT_LOCK, 1 FILTER, 2 RELEASE, 3 RUN.

## Operation
- **Lock synchronizer.** `FAB_LOCK` passes through a two-flop synchronizer, giving `lock_s`. Nothing else samples `FAB_LOCK`.
- **WAIT_LOCK.** All `RST_N` are 0 and `READY` is 0.
  - Exit: `lock_s`=1 and `HOLD`=0 → FILTER, with the filter counter set to 1.
- **FILTER.** The counter increments on each edge where `lock_s`=1.
  - `lock_s`=0 → WAIT_LOCK. This is not counted as a loss.
  - Counter reaches `LOCK_FILTER` → RELEASE. `RST_N[0]` goes to 1 on the same edge and the stagger counter is cleared.
- **RELEASE.** Every `STAGGER` cycles the next `RST_N` bit rises, in ascending index order.
  - On the edge that releases bit `NUM_DOMAINS-1` → RUN, with `READY`=1 on the same edge.
  - With `NUM_DOMAINS`=1, the edge that leaves FILTER goes directly to RUN.
- **RUN.** Outputs hold. `lock_s`=0 → WAIT_LOCK.
- **Lock loss.** `lock_s`=0 while in RELEASE or RUN causes:
  - all `RST_N` = 0 and `READY` = 0 on the next edge;
  - `LOCK_LOSS_CNT` increments on that same edge and saturates at 255.
- **HOLD.** `HOLD`=1 in any state → WAIT_LOCK on the next edge, with the same output effect as a loss but no count increment. If `HOLD` and a loss occur in the same cycle, the loss is counted.
- **CLR_STATUS.** Clears both status fields. When it coincides with an increment or a timeout set, the clear wins and the result is 0.
- **Watchdog.** A 16-bit counter runs while in WAIT_LOCK or FILTER with `HOLD`=0.
  - It is cleared on entry to RELEASE and whenever `HOLD`=1.
  - When it reaches `TIMEOUT_CYCLES`, `LOCK_TIMEOUT` is set to 1 and the counter stops.
  - The flag does not affect sequencing.
- **Asynchronous reset.** Asserting `RESET_N`, including mid-release, immediately forces the reset values on all outputs.

## Timing
- **Reset values:**
  - `RST_N` = all 0
  - `READY` = 0
  - `LOCK_LOSS_CNT` = 0
  - `LOCK_TIMEOUT` = 0
  - `STATE` = 0
  - synchronizer, filter, stagger and watchdog counters = 0
- **Release timing.** `FAB_LOCK` rises before edge 0 and then stays high.
  - `lock_s` is 1 after edge 1.
  - `RST_N[i]` is 1 after edge `1+LOCK_FILTER+i*STAGGER`.
  - `READY` rises with the last domain.
  - With defaults: bit 0 at edge 17, bit 1 at edge 21, bit 2 and `READY` at edge 25.
- **Loss timing.** `FAB_LOCK` falls before edge m. All resets are asserted, and the count increments, after edge m+2.
- **Glitch filtering.** A lock glitch shorter than 2 cycles may be missed. Any dropout seen on `lock_s` during FILTER restarts the filter.
- **Registered outputs.** All outputs are registered, with no combinational paths from inputs.

## Configuration
- Macro `CCC_LOCK_SEQ_WATCHDOG_EN`:
  - Defined: the watchdog counter and `LOCK_TIMEOUT` behave as above.
  - Undefined: no watchdog counter is built and `LOCK_TIMEOUT` is tied to 0.
  - All other behaviour is identical in both cases.

## Test plan
- **Nominal release.** Defaults; `FAB_LOCK`=1 from edge 0 → `RST_N` = 001 at edge 17, 011 at edge 21, 111 at edge 25; `READY`=1 at edge 25; `STATE`=3.
- **Filter dropout.** `FAB_LOCK` high 10 cycles, low 3 cycles, then high → no `RST_N` rises until 16 consecutive `lock_s` samples; `LOCK_LOSS_CNT` stays 0.
- **Loss in RUN and in RELEASE.** Drop `FAB_LOCK` at edge 40 → `RST_N`=000, `READY`=0, count=1 at edge 42. Relock, then drop between bit 0 and bit 1 release → count=2.
- **Saturation and clear.** Force 260 losses → count stays at 255. Pulse `CLR_STATUS` on the same cycle as a loss increment → count=0.
- **HOLD.** Assert `HOLD` in RUN → all resets asserted next edge, count unchanged. Release `HOLD` → full sequence repeats with the same cycle offsets from the first `lock_s` sample.
- **Watchdog and async reset.** `TIMEOUT_CYCLES`=100, `FAB_LOCK`=0 → `LOCK_TIMEOUT`=1 after 100 WAIT_LOCK cycles (macro defined), stays 0 with the macro undefined. Assert `RESET_N` low mid-RELEASE → all outputs at reset values immediately.
